inst_prefetch_queue: RTL and testbench

- Instruction prefetch stage between the memory bus and the CPU dispatch stage.
- Fetches sequential tetras (32-bit MMIX instructions) starting at a redirect address and buffers them, with their locations, in a small FIFO.
- Presents the FIFO head to dispatch.
- On a redirect (branch, trap, reset vector) it flushes the FIFO and discards any in-flight response.

---
 rtl/inst_prefetch_queue.sv | 212 +++++++++++++++++++++
 tb/tb_inst_prefetch_queue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// ============================================================================
// Module  : inst_prefetch_queue
// Brief   : Sequential tetra prefetcher feeding a DEPTH-entry instruction FIFO,
//           with redirect flush, in-flight response drain and a read watchdog.
//           Optional macro PREFETCH_STATS_EN adds discard/fetch statistics ports.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module inst_prefetch_queue #(
    parameter int DEPTH       = 4,
    parameter int MEM_LAT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [63:0] redirect_addr,
    input  logic        enable,
    output logic        head_valid,
    output logic [31:0] head_inst,
    output logic [63:0] head_loc,
    input  logic        head_pop,
    output logic [63:0] mem_address,
    output logic [1:0]  mem_datasize,
    output logic        mem_read,
    input  logic [63:0] mem_readdata,
    input  logic        mem_done,
    output logic        timeout
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0] stat_discards,
    output logic [31:0] stat_fetches
`endif
);

    localparam int             c_PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PW:0]  c_DEPTH   = (c_PW + 1)'(DEPTH);
    localparam logic [7:0]     c_LAT_MAX = 8'(MEM_LAT_MAX);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_REQ   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic            r_started;
    logic [63:0]     r_fetch_pc;
    logic [63:0]     r_mem_addr;
    logic [c_PW:0]   r_count;
    logic [c_PW-1:0] r_rd;
    logic [c_PW-1:0] r_wr;
    logic [31:0]     r_inst [DEPTH];
    logic [63:0]     r_loc  [DEPTH];
    logic [7:0]      r_wd;
    logic            r_timeout;

    logic w_busy;
    logic w_issue;
    logic w_push;
    logic w_pop;

    // Only the low tetra of the bus and the word-aligned part of the target matter.
    logic w_unused_bits;
    assign w_unused_bits = ^{mem_readdata[63:32], redirect_addr[1:0]};

    assign w_busy  = (r_state != c_IDLE);
    assign w_issue = (r_state == c_IDLE) && enable && r_started &&
                     (r_count < c_DEPTH) && !redirect;
    assign w_push  = (r_state == c_REQ) && mem_done && !redirect;
    assign w_pop   = head_pop && (r_count != '0) && !redirect;

    // ------------------------------------------------------------------------
    // Fetch state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_issue) begin
                    w_next_state = c_REQ;
                end
            end
            c_REQ: begin
                if (mem_done) begin
                    w_next_state = c_IDLE;
                end else if (redirect) begin
                    w_next_state = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (mem_done) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        mem_read = w_busy;
    end

    assign mem_address  = r_mem_addr;
    assign mem_datasize = 2'd2;

    // ------------------------------------------------------------------------
    // Fetch PC, request address and FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_started  <= 1'b0;
            r_fetch_pc <= '0;
            r_mem_addr <= '0;
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_inst[i] <= '0;
                r_loc[i]  <= '0;
            end
        end else begin
            if (w_issue) begin
                r_mem_addr <= r_fetch_pc;
            end
            // A redirect flushes everything queued and wins over any pop or push.
            if (redirect) begin
                r_started  <= 1'b1;
                r_fetch_pc <= {redirect_addr[63:2], 2'b00};
                r_count    <= '0;
                r_rd       <= '0;
                r_wr       <= '0;
            end else begin
                if (w_push) begin
                    r_inst[r_wr] <= mem_readdata[31:0];
                    r_loc[r_wr]  <= r_fetch_pc;
                    r_wr         <= r_wr + 1'b1;
                    r_fetch_pc   <= r_fetch_pc + 64'd4;
                end
                if (w_pop) begin
                    r_rd <= r_rd + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign head_valid = (r_count != '0);
    assign head_inst  = r_inst[r_rd];
    assign head_loc   = r_loc[r_rd];

    // ------------------------------------------------------------------------
    // Read watchdog: flags the (MEM_LAT_MAX+1)th busy cycle without a response
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else if (w_busy && !mem_done) begin
            if (r_wd == c_LAT_MAX) begin
                r_timeout <= 1'b1;
            end
            if (r_wd != 8'hFF) begin
                r_wd <= r_wd + 8'd1;
            end
        end else begin
            r_wd <= '0;
        end
    end

    assign timeout = r_timeout;

`ifdef PREFETCH_STATS_EN
    logic [15:0] r_stat_discards;
    logic [31:0] r_stat_fetches;
    logic        w_discard;

    assign w_discard = mem_done &&
                       (((r_state == c_REQ) && redirect) || (r_state == c_DRAIN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_discards <= '0;
            r_stat_fetches  <= '0;
        end else begin
            if (w_discard && (r_stat_discards != 16'hFFFF)) begin
                r_stat_discards <= r_stat_discards + 16'd1;
            end
            if (w_push) begin
                r_stat_fetches <= r_stat_fetches + 32'd1;
            end
        end
    end

    assign stat_discards = r_stat_discards;
    assign stat_fetches  = r_stat_fetches;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
// ============================================================================
// Module  : tb_inst_prefetch_queue
// Brief   : Directed self-checking bench for inst_prefetch_queue with a
//           fixed-latency memory responder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_prefetch_queue;

    localparam int c_DEPTH   = 4;
    localparam int c_LAT_MAX = 255;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [63:0] redirect_addr;
    logic        enable;
    logic        head_valid;
    logic [31:0] head_inst;
    logic [63:0] head_loc;
    logic        head_pop;
    logic [63:0] mem_address;
    logic [1:0]  mem_datasize;
    logic        mem_read;
    logic [63:0] mem_readdata;
    logic        mem_done;
    logic        timeout;
`ifdef PREFETCH_STATS_EN
    logic [15:0] stat_discards;
    logic [31:0] stat_fetches;
    logic [31:0] fetch_snap;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // memory responder state
    int          lat = 2;
    int          age = 0;
    logic        hang = 1'b0;
    logic        prev_read = 1'b0;
    logic        rose;
    logic [63:0] req_log[$];

    // occupancy model used while the queue drains under continuous pops
    logic        cnt_en = 1'b0;
    int          cnt_m = 0;
    int          full_viol = 0;

    inst_prefetch_queue #(
        .DEPTH       (c_DEPTH),
        .MEM_LAT_MAX (c_LAT_MAX)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .enable        (enable),
        .head_valid    (head_valid),
        .head_inst     (head_inst),
        .head_loc      (head_loc),
        .head_pop      (head_pop),
        .mem_address   (mem_address),
        .mem_datasize  (mem_datasize),
        .mem_read      (mem_read),
        .mem_readdata  (mem_readdata),
        .mem_done      (mem_done),
        .timeout       (timeout)
`ifdef PREFETCH_STATS_EN
        ,
        .stat_discards (stat_discards),
        .stat_fetches  (stat_fetches)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed 0x%h required 0x%h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock; the memory model reacts to what the DUT shows after the edge.
    task automatic tick();
        int pre;
        pre = cnt_m;
        if (cnt_en) begin
            if (mem_done) cnt_m++;
            if (head_pop && head_valid) cnt_m--;
        end
        @(posedge clk);
        #1;
        mem_done = 1'b0;
        if (mem_read && !hang) begin
            if (age == lat) begin
                mem_done     = 1'b1;
                mem_readdata = {32'hBAD0_BAD0, inst_of(mem_address)};
                age          = 0;
            end else begin
                age++;
            end
        end else begin
            age = 0;
        end
        rose = mem_read && !prev_read;
        if (rose) req_log.push_back(mem_address);
        if (cnt_en && rose && (pre >= c_DEPTH)) full_viol++;
        prev_read = mem_read;
    endtask

    task automatic do_redirect(input logic [63:0] a);
        redirect      = 1'b1;
        redirect_addr = a;
        tick();
        redirect      = 1'b0;
    endtask

    task automatic quiesce();
        enable   = 1'b0;
        head_pop = 1'b0;
        for (int i = 0; i < 60 && mem_read; i++) tick();
        check_val("quiesce_idle", {63'd0, mem_read}, 64'd0);
        req_log.delete();
        enable = 1'b1;
    endtask

    initial begin
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_addr = '0;
        enable        = 1'b0;
        head_pop      = 1'b0;
        mem_done      = 1'b0;
        mem_readdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_head_valid", {63'd0, head_valid}, 64'd0);
        check_val("rst_head_inst",  {32'd0, head_inst}, 64'd0);
        check_val("rst_head_loc",   head_loc, 64'd0);
        check_val("rst_mem_read",   {63'd0, mem_read}, 64'd0);
        check_val("rst_mem_addr",   mem_address, 64'd0);
        check_val("rst_timeout",    {63'd0, timeout}, 64'd0);
        check_val("datasize",       {62'd0, mem_datasize}, 64'd2);
        reset = 1'b0;

        // No request before the first redirect even with enable high
        enable = 1'b1;
        repeat (6) tick();
        check_val("no_req_before_redirect", req_log.size(), 0);

        // Fill: latency 2, no pops
        lat = 2;
        do_redirect(64'h8000_0000_0000_0100);
        repeat (40) tick();
        check_val("fill_req_count", req_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("fill_req_addr%0d", i), log_at(i), 64'h8000_0000_0000_0100 + 64'(4 * i));
        check_val("fill_mem_read_low", {63'd0, mem_read}, 64'd0);
        check_val("fill_head_valid", {63'd0, head_valid}, 64'd1);
        check_val("fill_head_loc", head_loc, 64'h8000_0000_0000_0100);
        check_val("fill_head_inst", {32'd0, head_inst}, {32'd0, inst_of(64'h8000_0000_0000_0100)});

        // Drain with a pop every cycle while fetching continues
        begin
            logic [63:0] exp_loc;
            int got;
            exp_loc  = 64'h8000_0000_0000_0100;
            got      = 0;
            cnt_m    = c_DEPTH;
            cnt_en   = 1'b1;
            head_pop = 1'b1;
            for (int i = 0; i < 200 && got < 8; i++) begin
                if (head_valid) begin
                    check_val($sformatf("pop_loc%0d", got), head_loc, exp_loc);
                    check_val($sformatf("pop_inst%0d", got), {32'd0, head_inst}, {32'd0, inst_of(exp_loc)});
                    exp_loc += 64'd4;
                    got++;
                end
                tick();
            end
            check_val("pop_items", got, 8);
            check_val("no_req_when_full", full_viol, 0);
            cnt_en = 1'b0;
        end

        // Redirect while the read of 0x108 is outstanding
        quiesce();
        lat = 5;
        do_redirect(64'h100);
        for (int i = 0; i < 100 && req_log.size() < 3; i++) tick();
        check_val("drain_third_req", log_at(2), 64'h108);
        do_redirect(64'h200);
        check_val("drain_flushed", {63'd0, head_valid}, 64'd0);
        check_val("drain_read_held", {63'd0, mem_read}, 64'd1);
        for (int i = 0; i < 50 && !mem_done; i++) tick();
        check_val("drain_done_seen", {63'd0, mem_done}, 64'd1);
        check_val("drain_done_addr", mem_address, 64'h108);
        for (int i = 0; i < 60 && !head_valid; i++) tick();
        check_val("drain_next_req", log_at(3), 64'h200);
        check_val("drain_head_loc", head_loc, 64'h200);
        check_val("drain_head_inst", {32'd0, head_inst}, {32'd0, inst_of(64'h200)});
`ifdef PREFETCH_STATS_EN
        check_val("stat_discards_1", {48'd0, stat_discards}, 64'd1);
`endif

        // Fetch address wraps at the top of the address space
        quiesce();
        lat = 1;
        do_redirect(64'hFFFF_FFFF_FFFF_FFFE);
`ifdef PREFETCH_STATS_EN
        fetch_snap = stat_fetches;
`endif
        for (int i = 0; i < 40 && req_log.size() < 2; i++) tick();
        check_val("wrap_req0", log_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
        check_val("wrap_req1", log_at(1), 64'h0);
        check_val("wrap_head_loc", head_loc, 64'hFFFF_FFFF_FFFF_FFFC);
`ifdef PREFETCH_STATS_EN
        check_val("stat_fetches_inc", {32'd0, stat_fetches}, {32'd0, fetch_snap + 32'd1});
`endif

        // Redirect, pop and response all in one cycle with two entries queued
        quiesce();
        lat = 3;
        do_redirect(64'h300);
        for (int i = 0; i < 60 && req_log.size() < 3; i++) tick();
        for (int i = 0; i < 20 && !mem_done; i++) tick();
        check_val("tri_done_addr", mem_address, 64'h308);
        check_val("tri_head_valid_before", {63'd0, head_valid}, 64'd1);
        head_pop = 1'b1;
        do_redirect(64'h400);
        head_pop = 1'b0;
        check_val("tri_empty", {63'd0, head_valid}, 64'd0);
        tick();
        check_val("tri_new_read", {63'd0, mem_read}, 64'd1);
        check_val("tri_new_addr", mem_address, 64'h400);
`ifdef PREFETCH_STATS_EN
        check_val("stat_discards_2", {48'd0, stat_discards}, 64'd2);
`endif

        // Memory never responds: watchdog
        quiesce();
        hang = 1'b1;
        do_redirect(64'h500);
        for (int i = 0; i < 10 && req_log.size() < 1; i++) tick();
        check_val("wd_req_seen", req_log.size(), 1);
        for (int k = 1; k <= c_LAT_MAX + 1; k++) begin
            tick();
            if (k == c_LAT_MAX) check_val("wd_not_yet", {63'd0, timeout}, 64'd0);
        end
        check_val("wd_timeout", {63'd0, timeout}, 64'd1);
        check_val("wd_read_held", {63'd0, mem_read}, 64'd1);
        check_val("wd_addr", mem_address, 64'h500);

        // Asynchronous reset abandons the request immediately
        #2 reset = 1'b1;
        #1;
        check_val("arst_mem_read", {63'd0, mem_read}, 64'd0);
        check_val("arst_timeout", {63'd0, timeout}, 64'd0);
        check_val("arst_mem_addr", mem_address, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        hang = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
